mem_line_responder: RTL and testbench

MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

---
 rtl/mem_line_if.sv | 22 ++
 rtl/mem_line_responder.sv | 98 +++++++++
 tb/tb_mem_line_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_line_if.sv
// mem_line_if: request/response bundle between a cache controller and mem_line_responder.
interface mem_line_if #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    logic              MStrobe;
    logic              MRW;
    logic [ADDR_W-1:0] MAddr;
    logic [DATA_W-1:0] MWData;
    logic [DATA_W-1:0] MRData;
    logic              MRValid;
    logic [OFF_W-1:0]  MWordIdx;
    logic              CtrSig;
    logic              MRdy;
    logic              Busy;
    modport master (output MStrobe, MRW, MAddr, MWData,
                    input  MRData, MRValid, MWordIdx, CtrSig, MRdy, Busy);
    modport slave  (input  MStrobe, MRW, MAddr, MWData,
                    output MRData, MRValid, MWordIdx, CtrSig, MRdy, Busy);
endinterface

// File: rtl/mem_line_responder.sv
// mem_line_responder: wait-stated backing memory answering line fills and single-word writes.
// Define MEM_LINE_BURST_EN for critical-word-first line bursts; otherwise reads return one word.
module mem_line_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int LINE_WORDS  = 4,
    parameter int WAIT_CYCLES = 3
) (
    input logic       clk,
    input logic       rst_n,
    mem_line_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int CNT_W = 4;
`ifdef MEM_LINE_BURST_EN
    localparam int BEATS = LINE_WORDS;
`else
    localparam int BEATS = 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_rw;
    logic [ADDR_W-1:0]        r_addr;
    logic [DATA_W-1:0]        r_wdata;
    logic [DATA_W-1:0]        r_rdata;
    logic                     r_rvalid;
    logic [OFF_W-1:0]         r_idx;
    logic [OFF_W-1:0]         r_left;
    logic [DATA_W-1:0]        r_mem [2**ADDR_W];

    logic [ADDR_W-OFF_W-1:0]  w_base;
    logic [OFF_W-1:0]         w_first;
    logic [OFF_W-1:0]         w_next;

    assign w_base  = r_addr[ADDR_W-1:OFF_W];
    assign w_first = r_addr[OFF_W-1:0];
    assign w_next  = r_idx + OFF_W'(1);

    assign bus.MRData   = r_rdata;
    assign bus.MRValid  = r_rvalid;
    assign bus.MWordIdx = r_idx;
    assign bus.CtrSig   = (r_state == S_WAIT) && (r_cnt == '0);
    assign bus.MRdy     = (r_state == S_DONE);
    assign bus.Busy     = (r_state != S_IDLE);

    // Storage is not reset; the write strobe derives from r_state so a reset aborts pending writes.
    always_ff @(posedge clk) begin
        if (r_state == S_XFER && !r_rw) r_mem[r_addr] <= r_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_idx    <= '0;
            r_left   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.MStrobe) begin
                    r_state <= S_WAIT;
                    r_rw    <= bus.MRW;
                    r_addr  <= bus.MAddr;
                    r_wdata <= bus.MWData;
                    r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
                end
                S_WAIT: if (r_cnt == '0) begin
                    r_state <= S_XFER;
                    if (r_rw) begin
                        r_rvalid <= 1'b1;
                        r_idx    <= w_first;
                        r_rdata  <= r_mem[{w_base, w_first}];
                        r_left   <= OFF_W'(BEATS - 1);
                    end
                end else r_cnt <= r_cnt - CNT_W'(1);
                // Offsets wrap inside the line because r_idx is exactly OFF_W bits wide.
                S_XFER: if (r_rw && r_left != '0) begin
                    r_idx   <= w_next;
                    r_rdata <= r_mem[{w_base, w_next}];
                    r_left  <= r_left - OFF_W'(1);
                end else begin
                    r_state  <= S_DONE;
                    r_rvalid <= 1'b0;
                    r_rdata  <= '0;
                    r_idx    <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: directed write/read/abort vectors against a reference copy of memory.
module tb_mem_line_responder;
    localparam int W = 3;
`ifdef MEM_LINE_BURST_EN
    localparam int BEATS = 4;
`else
    localparam int BEATS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model [256];

    mem_line_if #(.ADDR_W(8), .DATA_W(32), .LINE_WORDS(4)) bus ();

    mem_line_responder #(.ADDR_W(8), .DATA_W(32), .LINE_WORDS(4), .WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"},  32'(bus.Busy), 0);
        chk({tag, ".ctr"},   32'(bus.CtrSig), 0);
        chk({tag, ".valid"}, 32'(bus.MRValid), 0);
        chk({tag, ".idx"},   32'(bus.MWordIdx), 0);
        chk({tag, ".data"},  bus.MRData, 0);
        chk({tag, ".rdy"},   32'(bus.MRdy), 0);
    endtask

    // Called at a negedge; strobe is sampled on the next posedge (edge T), then cycle k is checked at
    // the k-th following negedge. abort_k>0 pulls rst_n low in cycle k instead of finishing.
    task automatic xact(input logic rw, input logic [7:0] addr, input logic [31:0] wd,
                        input bit hold, input int abort_k);
        int last;
        int off;
        bit valid;
        last = rw ? W + BEATS + 1 : W + 2;
        bus.MStrobe = 1'b1;
        bus.MRW     = rw;
        bus.MAddr   = addr;
        bus.MWData  = wd;
        @(posedge clk);
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                rst_n = 1'b0;
                bus.MStrobe = 1'b0;
                #1;
                chk_zero("abort");
                @(negedge clk);
                chk_zero("abort_hold");
                rst_n = 1'b1;
                return;
            end
            valid = rw && k > W && k <= W + BEATS;
            off   = (int'(addr[1:0]) + k - W - 1) % 4;
            chk($sformatf("busy@%0d", k),  32'(bus.Busy), 32'(k <= last));
            chk($sformatf("ctr@%0d", k),   32'(bus.CtrSig), 32'(k == W));
            chk($sformatf("valid@%0d", k), 32'(bus.MRValid), 32'(valid));
            chk($sformatf("rdy@%0d", k),   32'(bus.MRdy), 32'(k == last));
            if (valid) begin
                chk($sformatf("idx@%0d", k),  32'(bus.MWordIdx), 32'(off));
                chk($sformatf("data@%0d", k), bus.MRData, model[{addr[7:2], 2'(off)}]);
            end
            if (hold && k <= last) begin
                bus.MAddr  = bus.MAddr ^ 8'h3C;
                bus.MWData = ~bus.MWData;
                bus.MRW    = ~bus.MRW;
            end else bus.MStrobe = 1'b0;
        end
        if (!rw) model[addr] = wd;
    endtask

    initial begin
        bus.MStrobe = 1'b0;
        bus.MRW     = 1'b0;
        bus.MAddr   = '0;
        bus.MWData  = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) xact(1'b0, 8'h04 + 8'(i), 32'hA0 + 32'(i), 1'b0, 0);
        for (int i = 0; i < 4; i++) xact(1'b0, 8'h10 + 8'(i), 32'hA4 + 32'(i), 1'b0, 0);
        xact(1'b1, 8'h06, '0, 1'b0, 0);
        xact(1'b1, 8'h11, '0, 1'b1, 0);
        @(negedge clk);
        chk("hold_requeue.busy", 32'(bus.Busy), 0);
        xact(1'b1, 8'h06, '0, 1'b0, W + 2);
        xact(1'b1, 8'h04, '0, 1'b0, 0);
        xact(1'b0, 8'h05, 32'hFF, 1'b0, 2);
        xact(1'b1, 8'h05, '0, 1'b0, 0);
        xact(1'b1, 8'h12, '0, 1'b0, 0);
        chk("model_05", model[8'h05], 32'hA1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
